// File: rtl/i2c_mem_arbiter_if.sv
// Bus bundle between the I2C slave, the local fabric port, the memory macro and the arbiter.
// The arbiter connects through the slave modport; the surrounding environment uses master.
interface i2c_mem_arbiter_if #(
  parameter int MEM_AW = 4
);
  logic              i2c_rw;
  logic [7:0]        i2c_addr;
  logic              i2c_wen;
  logic [7:0]        i2c_wdata;
  logic              i2c_rdata_used;
  logic [7:0]        i2c_rdata;
  logic              loc_req;
  logic              loc_we;
  logic [MEM_AW-1:0] loc_addr;
  logic [7:0]        loc_wdata;
  logic              loc_gnt;
  logic              loc_rvalid;
  logic [7:0]        loc_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              wr_ovf;

  modport slave (
    input  i2c_rw, i2c_addr, i2c_wen, i2c_wdata, i2c_rdata_used,
    input  loc_req, loc_we, loc_addr, loc_wdata, mem_rdata,
    output i2c_rdata, loc_gnt, loc_rvalid, loc_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, wr_ovf
  );

  modport master (
    output i2c_rw, i2c_addr, i2c_wen, i2c_wdata, i2c_rdata_used,
    output loc_req, loc_we, loc_addr, loc_wdata, mem_rdata,
    input  i2c_rdata, loc_gnt, loc_rvalid, loc_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, wr_ovf
  );
endinterface

// File: rtl/i2c_mem_arbiter.sv
// Single-port register memory scheduler: posted I2C writes, always-ready I2C read prefetch,
// local req/gnt port on leftover cycles. Define REGARB_RO_EN to block I2C writes at/above RO_BASE.
module i2c_mem_arbiter #(
  parameter int         MEM_AW  = 4,
  parameter logic [7:0] RO_BASE = 8'hC0
) (
  input  logic             clk,
  input  logic             rst_n,
  i2c_mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, I2C_WR, PF_RD, PF_CAP, LOC_WR, LOC_RD, LOC_CAP
  } state_t;

  state_t            state, state_nx;
  logic              wr_pend, wr_ovf;
  logic [MEM_AW-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              pf_stale, pf_stale_nx;
  logic [7:0]        pf_addr, pf_addr_nx;
  logic [7:0]        i2c_rdata, loc_rdata_q;
  logic              addr_ok, ro_blk, wr_accept, rd_used, wr_hit, pf_take, pf_zero;
  logic              mem_en, mem_we, loc_gnt;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  function automatic logic in_range(input logic [7:0] a);
    return (32'(a) >> MEM_AW) == 32'd0;
  endfunction

  assign addr_ok = in_range(bus.i2c_addr);

`ifdef REGARB_RO_EN
  assign ro_blk = (bus.i2c_addr >= RO_BASE);
`else
  // Read-only window disabled: every in-range I2C write is accepted.
  assign ro_blk = 1'b0 & (bus.i2c_addr >= RO_BASE);
`endif

  assign wr_accept = bus.i2c_wen && addr_ok && !ro_blk;
  assign rd_used   = bus.i2c_rdata_used && bus.i2c_rw;
  assign wr_hit    = mem_en && mem_we && (8'(mem_addr) == pf_addr);

  always_comb begin
    state_nx  = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    loc_gnt   = 1'b0;
    pf_zero   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_pend || wr_accept) begin
          state_nx = I2C_WR;
        end else if (pf_stale) begin
          // Out-of-range prefetch resolves to zero here, without touching memory.
          if (addr_ok) state_nx = PF_RD;
          else         pf_zero  = 1'b1;
        end else if (bus.loc_req) begin
          state_nx = bus.loc_we ? LOC_WR : LOC_RD;
        end
      end
      I2C_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        state_nx  = IDLE;
      end
      PF_RD: begin
        if (addr_ok) begin
          mem_en   = 1'b1;
          mem_addr = bus.i2c_addr[MEM_AW-1:0];
          state_nx = PF_CAP;
        end else begin
          state_nx = IDLE;
        end
      end
      PF_CAP:  state_nx = IDLE;
      LOC_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = bus.loc_addr;
        mem_wdata = bus.loc_wdata;
        loc_gnt   = 1'b1;
        state_nx  = IDLE;
      end
      LOC_RD: begin
        mem_en   = 1'b1;
        mem_addr = bus.loc_addr;
        loc_gnt  = 1'b1;
        state_nx = LOC_CAP;
      end
      LOC_CAP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Staleness sets win over the clear so a hit during PF_CAP re-runs the prefetch.
  always_comb begin
    pf_take     = ((state == PF_RD) && addr_ok) || pf_zero;
    pf_addr_nx  = pf_take ? bus.i2c_addr : pf_addr;
    pf_stale_nx = pf_take ? 1'b0 : pf_stale;
    if ((bus.i2c_addr != pf_addr_nx) || rd_used || wr_hit) pf_stale_nx = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_pend     <= 1'b0;
      wr_ovf      <= 1'b0;
      pf_stale    <= 1'b1;
      pf_addr     <= 8'h00;
      i2c_rdata   <= 8'h00;
      loc_rdata_q <= 8'h00;
    end else begin
      state    <= state_nx;
      pf_stale <= pf_stale_nx;
      pf_addr  <= pf_addr_nx;
      if (wr_accept) begin
        wr_pend <= 1'b1;
        // A write landing in the same cycle the buffer retires is not an overflow.
        if (wr_pend && (state != I2C_WR)) wr_ovf <= 1'b1;
      end else if (state == I2C_WR) begin
        wr_pend <= 1'b0;
      end
      if (pf_zero)                i2c_rdata <= 8'h00;
      else if (state == PF_CAP)   i2c_rdata <= bus.mem_rdata;
      if (state == LOC_CAP)       loc_rdata_q <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      wr_addr <= bus.i2c_addr[MEM_AW-1:0];
      wr_data <= bus.i2c_wdata;
    end
  end

  assign bus.i2c_rdata  = i2c_rdata;
  assign bus.loc_gnt    = loc_gnt;
  assign bus.loc_rvalid = (state == LOC_CAP);
  assign bus.loc_rdata  = (state == LOC_CAP) ? bus.mem_rdata : loc_rdata_q;
  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.wr_ovf     = wr_ovf;

endmodule

// File: tb/tb_i2c_mem_arbiter.sv
// Bench for i2c_mem_arbiter: directed scenarios plus randomized serialized traffic checked
// against a flat array model of memory contents and the prefetch/grant rules.
module tb_i2c_mem_arbiter;

`ifdef REGARB_RO_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif
  localparam logic [7:0] RO_B = 8'h08;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2c_mem_arbiter_if #(.MEM_AW(4)) bus ();

  i2c_mem_arbiter #(.MEM_AW(4), .RO_BASE(RO_B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory macro: 1-cycle read latency, plus a bench-side init port.
  logic [7:0] mem [16];
  logic       init_we;
  logic [3:0] init_addr;
  logic [7:0] init_data;
  always @(posedge clk) begin
    if (init_we) mem[init_addr] <= init_data;
    else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  logic [7:0] ref_mem [16];
  int n_pass = 0;
  int n_total = 0;
  int pre_nw;
  logic [7:0] pre_wa, pre_wd;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pf_exp(input logic [7:0] a);
    return (a < 8'd16) ? ref_mem[a[3:0]] : 8'h00;
  endfunction

  task automatic run(input int n, output int ne, output int nw,
                     output logic [7:0] wa, output logic [7:0] wd);
    ne = 0; nw = 0; wa = 8'h00; wd = 8'h00;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.mem_en) ne++;
      if (bus.mem_en && bus.mem_we) begin
        nw++;
        wa = 8'(bus.mem_addr);
        wd = bus.mem_wdata;
      end
    end
  endtask

  task automatic i2c_write(input logic [7:0] a, input logic [7:0] d);
    int nw, first;
    logic [7:0] wa, wd;
    bit lands;
    bus.i2c_addr = a; bus.i2c_wdata = d; bus.i2c_wen = 1'b1;
    nw = 0; first = 0; wa = 8'h00; wd = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      tick();
      bus.i2c_wen = 1'b0;
      if (bus.mem_en && bus.mem_we) begin
        nw++;
        if (first == 0) first = i;
        wa = 8'(bus.mem_addr);
        wd = bus.mem_wdata;
      end
    end
    lands = (a < 8'd16) && !(RO_EN && (a >= RO_B));
    check("i2c_wr_count", 32'(nw), 32'(lands));
    if (lands) begin
      check("i2c_wr_latency_le3", 32'(first >= 1 && first <= 3), 1);
      check("i2c_wr_addr", 32'(wa), 32'(a));
      check("i2c_wr_data", 32'(wd), 32'(d));
      ref_mem[a[3:0]] = d;
    end
  endtask

  task automatic loc_xfer(input bit we, input logic [3:0] a, input logic [7:0] d, input int max_lat);
    int lat;
    bit got;
    bus.loc_req = 1'b1; bus.loc_we = we; bus.loc_addr = a; bus.loc_wdata = d;
    lat = 0; got = 1'b0; pre_nw = 0; pre_wa = 8'h00; pre_wd = 8'h00;
    while (!got && lat < 20) begin
      tick();
      bus.i2c_wen = 1'b0;
      lat++;
      if (bus.loc_gnt) got = 1'b1;
      else if (bus.mem_en && bus.mem_we) begin
        pre_nw++;
        pre_wa = 8'(bus.mem_addr);
        pre_wd = bus.mem_wdata;
      end
    end
    bus.loc_req = 1'b0;
    check("loc_gnt_seen", 32'(got), 1);
    if (got) begin
      check("loc_gnt_latency", 32'(lat <= max_lat), 1);
      if (we) ref_mem[a] = d;
      else begin
        tick();
        check("loc_rvalid", 32'(bus.loc_rvalid), 1);
        check("loc_rdata", 32'(bus.loc_rdata), 32'(ref_mem[a]));
        tick();
        check("loc_rvalid_pulse", 32'(bus.loc_rvalid), 0);
        check("loc_rdata_hold", 32'(bus.loc_rdata), 32'(ref_mem[a]));
      end
    end
  endtask

  initial begin
    int ne, nw, op;
    logic [7:0] wa, wd, cur, nxt;

    rst_n = 1'b0; init_we = 1'b0; init_addr = 4'h0; init_data = 8'h00;
    bus.i2c_rw = 1'b0; bus.i2c_addr = 8'h00; bus.i2c_wen = 1'b0; bus.i2c_wdata = 8'h00;
    bus.i2c_rdata_used = 1'b0; bus.loc_req = 1'b0; bus.loc_we = 1'b0;
    bus.loc_addr = 4'h0; bus.loc_wdata = 8'h00;
    for (int i = 0; i < 16; i++) begin
      init_addr = 4'(i);
      init_data = (i == 0) ? 8'h5A : 8'(i * 37 + 5);
      ref_mem[i] = init_data;
      init_we = 1'b1;
      tick();
    end
    init_we = 1'b0;
    tick();
    check("rst_i2c_rdata", 32'(bus.i2c_rdata), 0);
    check("rst_loc_gnt", 32'(bus.loc_gnt), 0);
    check("rst_loc_rvalid", 32'(bus.loc_rvalid), 0);
    check("rst_loc_rdata", 32'(bus.loc_rdata), 0);
    check("rst_mem_en", 32'(bus.mem_en), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    check("rst_wr_ovf", 32'(bus.wr_ovf), 0);

    // Reset release: one prefetch of address 0, data ready by cycle 3.
    rst_n = 1'b1;
    check("idle_c0_mem_en", 32'(bus.mem_en), 0);
    run(3, ne, nw, wa, wd);
    check("boot_pf_count", 32'(ne), 1);
    check("boot_pf_data", 32'(bus.i2c_rdata), 32'h5A);
    run(6, ne, nw, wa, wd);
    check("boot_idle_mem_en", 32'(ne), 0);

    // Simultaneous I2C write and local read: the write goes first.
    bus.i2c_addr = 8'h03; bus.i2c_wdata = 8'hA5; bus.i2c_wen = 1'b1;
    loc_xfer(1'b0, 4'h7, 8'h00, 8);
    check("contend_pre_writes", 32'(pre_nw), 1);
    check("contend_wr_addr", 32'(pre_wa), 32'h03);
    check("contend_wr_data", 32'(pre_wd), 32'hA5);
    ref_mem[3] = 8'hA5;

    // Local write to the prefetched address triggers a re-prefetch.
    run(8, ne, nw, wa, wd);
    check("pf_addr3", 32'(bus.i2c_rdata), 32'hA5);
    loc_xfer(1'b1, 4'h3, 8'h11, 1);
    run(5, ne, nw, wa, wd);
    check("repf_count", 32'(ne), 1);
    check("repf_data", 32'(bus.i2c_rdata), 32'h11);

    // Out-of-range I2C address.
    bus.i2c_addr = 8'h20;
    run(8, ne, nw, wa, wd);
    check("oor_mem_en", 32'(ne), 0);
    check("oor_rdata", 32'(bus.i2c_rdata), 0);
    i2c_write(8'h20, 8'h77);
    check("oor_mem0_intact", 32'(mem[0]), 32'(ref_mem[0]));
    check("oor_no_ovf", 32'(bus.wr_ovf), 0);

    // Read-only window (only blocks when REGARB_RO_EN is defined).
    i2c_write(8'h09, 8'h99);
    loc_xfer(1'b1, 4'h9, 8'h44, 1);
    run(8, ne, nw, wa, wd);
    check("ro_loc_write", 32'(mem[9]), 32'h44);
    check("ro_pf_data", 32'(bus.i2c_rdata), 32'h44);

    // Randomized serialized traffic.
    cur = bus.i2c_addr;
    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0: begin
          i2c_write(8'($urandom_range(0, 31)), 8'($urandom));
          cur = bus.i2c_addr;
        end
        1: loc_xfer(1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 1);
        2: loc_xfer(1'b0, 4'($urandom_range(0, 15)), 8'h00, 1);
        3: begin
          nxt = 8'($urandom_range(0, 31));
          bus.i2c_addr = nxt;
        end
        default: begin
          bus.i2c_rw = 1'b1; bus.i2c_rdata_used = 1'b1;
          tick();
          bus.i2c_rw = 1'b0; bus.i2c_rdata_used = 1'b0;
        end
      endcase
      run(8, ne, nw, wa, wd);
      if (op == 3) begin
        check("rnd_addr_pf_reads", 32'(ne), 32'((nxt != cur) && (nxt < 8'd16)));
        cur = nxt;
      end
      if (op == 4) check("rnd_used_pf_reads", 32'(ne), 32'(cur < 8'd16));
      check("rnd_prefetch", 32'(bus.i2c_rdata), 32'(pf_exp(cur)));
    end
    check("rnd_no_ovf", 32'(bus.wr_ovf), 0);

    // Two writes back to back while a local read occupies the port.
    bus.i2c_addr = 8'h05;
    run(8, ne, nw, wa, wd);
    bus.loc_req = 1'b1; bus.loc_we = 1'b0; bus.loc_addr = 4'h2;
    tick();
    check("ovf_gnt", 32'(bus.loc_gnt), 1);
    bus.loc_req = 1'b0;
    bus.i2c_wdata = 8'h31; bus.i2c_wen = 1'b1;
    tick();
    check("ovf_rvalid", 32'(bus.loc_rvalid), 1);
    check("ovf_rdata", 32'(bus.loc_rdata), 32'(ref_mem[2]));
    bus.i2c_addr = 8'h06; bus.i2c_wdata = 8'h62;
    tick();
    bus.i2c_wen = 1'b0;
    run(8, ne, nw, wa, wd);
    check("ovf_flag", 32'(bus.wr_ovf), 1);
    check("ovf_write_count", 32'(nw), 1);
    check("ovf_write_addr", 32'(wa), 32'h06);
    check("ovf_write_data", 32'(wd), 32'h62);
    ref_mem[6] = 8'h62;
    check("ovf_first_lost", 32'(mem[5]), 32'(ref_mem[5]));

    // Reset mid-operation drops the buffered write and clears the overflow flag.
    bus.loc_req = 1'b1; bus.loc_we = 1'b0; bus.loc_addr = 4'h1;
    tick();
    bus.loc_req = 1'b0;
    bus.i2c_addr = 8'h04; bus.i2c_wdata = 8'hEE; bus.i2c_wen = 1'b1;
    tick();
    bus.i2c_wen = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    check("mid_rst_ovf", 32'(bus.wr_ovf), 0);
    check("mid_rst_rvalid", 32'(bus.loc_rvalid), 0);
    check("mid_rst_mem_en", 32'(bus.mem_en), 0);
    rst_n = 1'b1;
    run(8, ne, nw, wa, wd);
    check("mid_rst_no_write", 32'(nw), 0);
    check("mid_rst_pf", 32'(bus.i2c_rdata), 32'(ref_mem[4]));

    for (int i = 0; i < 16; i++) check("mem_final", 32'(mem[4'(i)]), 32'(ref_mem[4'(i)]));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
